tmr_serial_tx: RTL and testbench
================================

Name: tmr_serial_tx

Overview:
- Transmit side of the triple-redundant serial link. The receive end votes 2-of-3 across three replicated lines.
- Accepts a parallel word over a val/rdy handshake and serialises it as a UART-style frame (start, data LSB-first, stop).
- Drives the frame identically on three output lines, so a single stuck or flipped line is masked by the downstream majority voter.

Parameters:
- NBITS, 8, data bits per frame (1..16)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NBITS  word to transmit; sampled only on handshake
- in_val  input  1  producer has valid in_data
- in_rdy  output  1  transmitter can accept a word
- out0  output  1  serial line copy 0 (idle high)
- out1  output  1  serial line copy 1 (identical to out0)
- out2  output  1  serial line copy 2 (identical to out0)
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Clock and reset: single clock domain. rst_n asynchronous, active-low, released synchronously by the integrator.
- Reset values: state=IDLE, out0/out1/out2=1, in_rdy=1, busy=0, counters=0, shift register=0.
- Reset mid-frame aborts immediately; lines return high asynchronously and no partial frame is resumed.
- Handshake: a transfer occurs on a rising edge with in_val && in_rdy. in_rdy = (state==IDLE); it is combinational from state and never depends on in_val. in_data is latched into the shift register on the transfer edge.
- FSM states IDLE, START, DATA, [PARITY], STOP:
  - IDLE -> START on transfer.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP (or PARITY) after NBITS bits.
  - PARITY -> STOP after one bit time.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Line value per state: START drives 0; DATA drives shift[0], shifting right once per bit time; STOP drives 1; IDLE drives 1.
- Outputs are registered. The first start-bit cycle appears on the lines in the cycle immediately after the transfer edge.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. The bit counter counts 0..NBITS-1 and wraps on the DATA exit. The bit counter is $clog2(NBITS) bits, minimum 1.
- Frame length is F = (NBITS+2[+1 parity])*CLKS_PER_BIT cycles. in_rdy reasserts in cycle F after the transfer edge, so back-to-back frames are separated by exactly one idle cycle at minimum.
- in_val asserted while busy is ignored. The word is held by the producer until accepted; no buffering beyond one word.
- in_data changes while busy have no effect on the frame.
- CLKS_PER_BIT=1 is legal: each bit lasts one cycle.
- out0, out1 and out2 are driven from three separate flops, not one fanned-out flop, so each copy has an independent register.

Optional Feature:
- Macro: TMR_TX_PARITY_EN.
- With the macro defined: a PARITY state is inserted between DATA and STOP and drives even parity (XOR of all NBITS data bits) for CLKS_PER_BIT cycles. Frame length grows by CLKS_PER_BIT.
- Without the macro: no PARITY state or logic exists, and DATA goes directly to STOP.

Decomposition:
- Shared package tmr_link_pkg holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit)
  - line idle level LINE_IDLE=1
  - start level LINE_START=0
  - these are shared with the receive-side framer.
- One natural sub-module, tmr_bit_timer:
  - parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick.
  - tick pulses on the last cycle of each bit time; clear is asserted on the transfer edge.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> out0..2=1, in_rdy=1, busy=0. Assert rst_n=0 mid-DATA -> lines go to 1 without waiting for clk.
- Single frame, NBITS=8, CLKS_PER_BIT=4, in_data=8'hA5, in_val for 1 cycle:
  - cycles 0-3: line 0.
  - cycles 4-35: bits 1,0,1,0,0,1,0,1 (4 cycles each).
  - cycles 36-39: line 1.
  - in_rdy=1 at cycle 40. All three lines match every cycle.
- Back-to-back: in_val held high with 8'h00 then 8'hFF -> second start bit begins at cycle 41. in_rdy is low for cycles 0-39 of each frame.
- Ignore while busy: pulse in_val with 8'h3C at cycle 10 of a frame, and change in_data mid-frame -> frame bits are unchanged and 8'h3C is not sent.
- CLKS_PER_BIT=1, in_data=8'h01 -> line sequence 0,1,0,0,0,0,0,0,0,1, then idle high. in_rdy reasserts 10 cycles after the transfer.
- With TMR_TX_PARITY_EN, in_data=8'h07, CLKS_PER_BIT=4 -> parity bit 1 for cycles 36-39, stop for cycles 40-43, in_rdy at cycle 44. With in_data=8'h03 -> parity bit 0.

Source files
------------

// File: rtl/tmr_link_pkg.sv
// Shared definitions for the triple-redundant serial link (transmit and receive framers).
package tmr_link_pkg;

    // Framer state encoding, common to both ends of the link.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tmr_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tmr_bit_timer.sv
// Bit-time divider: tick marks the last cycle of each serial bit; clear restarts the bit time.
module tmr_bit_timer
    import tmr_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: restart on clear or at the end of a bit time.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tmr_serial_tx.sv
// Triple-redundant UART-style transmitter: start, NBITS data LSB-first, optional even parity
// (enabled by defining TMR_TX_PARITY_EN), stop. The frame is driven on three independent flops.
module tmr_serial_tx
    import tmr_link_pkg::*;
#(
    parameter int unsigned NBITS        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBITS-1:0] in_data,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out0,
    output logic             out1,
    output logic             out2,
    output logic             busy
);

    localparam int unsigned BW = cnt_width(NBITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    tmr_state_e       state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             line_d;
    logic             out0_q, out1_q, out2_q;
    logic             tick;
    logic             transfer;
`ifdef TMR_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign in_rdy   = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign transfer = in_val && in_rdy;

    tmr_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (transfer),
        .tick  (tick)
    );

    // Next-state, shift/bit-counter update and the line level for the coming cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        line_d  = LINE_IDLE;
`ifdef TMR_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    state_d = StStart;
                    shift_d = in_data;
`ifdef TMR_TX_PARITY_EN
                    parity_d = ^in_data;
`endif
                end
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef TMR_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef TMR_TX_PARITY_EN
            StParity: begin
                if (tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Lines are registered, so the level follows the state being entered.
        unique case (state_d)
            StStart:  line_d = LINE_START;
            StData:   line_d = shift_d[0];
`ifdef TMR_TX_PARITY_EN
            StParity: line_d = parity_q;
`endif
            default:  line_d = LINE_IDLE;
        endcase
    end

    // State, datapath and the three independent line flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            out0_q  <= LINE_IDLE;
            out1_q  <= LINE_IDLE;
            out2_q  <= LINE_IDLE;
`ifdef TMR_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            out0_q  <= line_d;
            out1_q  <= line_d;
            out2_q  <= line_d;
`ifdef TMR_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule

// File: tb/tb_tmr_serial_tx.sv
// Bench for tmr_serial_tx: two instances (CLKS_PER_BIT=4 and 1) share stimulus; a frame-level
// model predicts every line/handshake value per cycle. Honours TMR_TX_PARITY_EN.
module tb_tmr_serial_tx;

`ifdef TMR_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_val = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       rdy4, busy4, a4, b4, c4;
    logic       rdy1, busy1, a1, b1, c1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycle index within the current frame (-1 = idle) and the word being sent.
    int         idx4 = -1, idx1 = -1;
    int         acc4 = 0;
    logic [7:0] w4 = 8'h00, w1 = 8'h00;

    always #5 clk = ~clk;

    tmr_serial_tx #(.NBITS(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_val(in_val), .in_rdy(rdy4),
        .out0(a4), .out1(b4), .out2(c4), .busy(busy4)
    );

    tmr_serial_tx #(.NBITS(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_val(in_val), .in_rdy(rdy1),
        .out0(a1), .out1(b1), .out2(c1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int flen(input int cpb);
        return (10 + PBITS) * cpb;
    endfunction

    // Line level at cycle idx of a frame carrying w, from the frame layout alone.
    function automatic logic exp_line(input logic [7:0] w, input int cpb, input int idx);
        int b;
        b = idx / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
`ifdef TMR_TX_PARITY_EN
        if (b == 9) return ^w;
`endif
        return 1'b1;
    endfunction

    // Model advance: a running frame counts on; an idle transmitter accepts a valid word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx4 <= -1;
            idx1 <= -1;
        end else begin
            if (idx4 >= 0) begin
                idx4 <= (idx4 + 1 == flen(4)) ? -1 : idx4 + 1;
            end else if (in_val) begin
                idx4 <= 0;
                w4   <= in_data;
                acc4 <= acc4 + 1;
            end
            if (idx1 >= 0) begin
                idx1 <= (idx1 + 1 == flen(1)) ? -1 : idx1 + 1;
            end else if (in_val) begin
                idx1 <= 0;
                w1   <= in_data;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("line4", 32'({a4, b4, c4}), (idx4 < 0) ? 32'd7 : 32'({3{exp_line(w4, 4, idx4)}}));
        check("rdy4", 32'(rdy4), 32'(idx4 < 0));
        check("busy4", 32'(busy4), 32'(idx4 >= 0));
        check("line1", 32'({a1, b1, c1}), (idx1 < 0) ? 32'd7 : 32'({3{exp_line(w1, 1, idx1)}}));
        check("rdy1", 32'(rdy1), 32'(idx1 < 0));
        check("busy1", 32'(busy1), 32'(idx1 >= 0));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_one(input logic [7:0] w, input int gap);
        in_val  = 1'b1;
        in_data = w;
        cyc(1);
        in_val  = 1'b0;
        in_data = 8'($urandom);
        cyc(gap);
    endtask

    initial begin
        int target;
        bit got_it;

        // Reset held for three cycles.
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        send_one(8'hA5, 50);

        // Back-to-back: 00 then FF with in_val held throughout.
        in_val  = 1'b1;
        in_data = 8'h00;
        cyc(1);
        in_data = 8'hFF;
        target  = acc4 + 1;
        got_it  = 1'b0;
        for (int i = 0; i < 100 && !got_it; i++) begin
            cyc(1);
            if (acc4 >= target) got_it = 1'b1;
        end
        check("b2b_accept", 32'(got_it), 32'd1);
        in_val = 1'b0;
        cyc(50);

        // Pulse in_val and disturb in_data while busy.
        in_val  = 1'b1;
        in_data = 8'h5A;
        cyc(1);
        in_val = 1'b0;
        cyc(9);
        in_val  = 1'b1;
        in_data = 8'h3C;
        cyc(1);
        in_val  = 1'b0;
        in_data = 8'hC3;
        cyc(45);

        send_one(8'h01, 50);
        send_one(8'h07, 50);
        send_one(8'h03, 50);

        // Randomised traffic.
        repeat (800) begin
            in_val  = ($urandom_range(0, 3) == 0);
            in_data = 8'($urandom);
            cyc(1);
        end
        in_val = 1'b0;
        cyc(50);

        // Asynchronous reset in the middle of the data bits.
        send_one(8'hA5, 15);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_line4", 32'({a4, b4, c4}), 32'd7);
        check("arst_rdy4", 32'(rdy4), 32'd1);
        check("arst_busy4", 32'(busy4), 32'd0);
        check("arst_line1", 32'({a1, b1, c1}), 32'd7);
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        send_one(8'h96, 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
